// File: rtl/pe_pkg.sv
// Constants and result types shared between pe_array and pe_result_collector.
package pe_pkg;

    localparam int ARRAY_WIDTH = 8;
    localparam int MAC_W       = 19;
    localparam int VEC_NUM     = 8;
    localparam int FIFO_DEPTH  = 8;

    typedef logic [MAC_W-1:0] mac_t;
    typedef mac_t [ARRAY_WIDTH-1:0] mac_vec_t;

endpackage

// File: rtl/pe_col_fifo.sv
// Single-clock FIFO holding one column's MAC results until the whole row vector is present.
module pe_col_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);

endmodule

// File: rtl/pe_result_collector.sv
// Re-aligns skewed pe_array column results into row vectors on a valid/ready stream.
// Optional PE_COLLECT_RELU_EN zeroes negative lanes at the output.
module pe_result_collector
    import pe_pkg::*;
#(
    parameter int ARRAY_WIDTH = pe_pkg::ARRAY_WIDTH,
    parameter int MAC_W       = pe_pkg::MAC_W,
    parameter int FIFO_DEPTH  = pe_pkg::FIFO_DEPTH,
    parameter int VEC_NUM     = pe_pkg::VEC_NUM
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_vi,
    input  logic [ARRAY_WIDTH-1:0][MAC_W-1:0] mac_i,
    input  logic [ARRAY_WIDTH-1:0]            mac_v_i,
    output logic [ARRAY_WIDTH-1:0][MAC_W-1:0] res_o,
    output logic                              res_v_o,
    input  logic                              res_ready_i,
    output logic                              res_last_o,
    output logic                              ovf_o
);

    localparam int CNT_W = (VEC_NUM > 1) ? $clog2(VEC_NUM) : 1;

    logic [ARRAY_WIDTH-1:0][MAC_W-1:0] head;
    logic [ARRAY_WIDTH-1:0]            full_vec;
    logic [ARRAY_WIDTH-1:0]            empty_vec;
    logic [ARRAY_WIDTH-1:0]            drop_vec;
    logic [CNT_W-1:0]                  vec_cnt;
    logic                              clr;
    logic                              pop;

    assign clr = rst_i || start_vi;
    assign pop = res_v_o && res_ready_i;

    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
        pe_col_fifo #(
            .W     (MAC_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .clr_i   (clr),
            .push_i  (mac_v_i[c]),
            .data_i  (mac_i[c]),
            .pop_i   (pop),
            .head_o  (head[c]),
            .full_o  (full_vec[c]),
            .empty_o (empty_vec[c])
        );
    end

    assign res_v_o    = &(~empty_vec);
    assign res_last_o = res_v_o && (vec_cnt == CNT_W'(VEC_NUM - 1));

    // The array cannot be stalled, so a push into a full, non-popping FIFO is lost.
    assign drop_vec = mac_v_i & full_vec & {ARRAY_WIDTH{~pop}};

    always_ff @(posedge clk_i) begin
        if (clr) begin
            vec_cnt <= '0;
            ovf_o   <= 1'b0;
        end else begin
            if (pop) begin
                vec_cnt <= (vec_cnt == CNT_W'(VEC_NUM - 1)) ? '0 : vec_cnt + CNT_W'(1);
            end
            if (|drop_vec) begin
                ovf_o <= 1'b1;
            end
        end
    end

    always_comb begin
        res_o = head;
`ifdef PE_COLLECT_RELU_EN
        for (int c = 0; c < ARRAY_WIDTH; c++) begin
            if (head[c][MAC_W-1]) begin
                res_o[c] = '0;
            end
        end
`endif
    end

endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Downstream stage of `pe_array`: captures the skewed per-column MAC results leaving the array's last row (`mac_o`/`mac_v_o`) and re-aligns them into full row vectors. It presents those vectors on a valid/ready stream to the writeback logic. Per-column FIFOs absorb the column skew and short consumer stalls. The array cannot be stalled, so overflow is flagged rather than back-pressured.

## Interface
Parameters:
- `ARRAY_WIDTH`, 8, number of PE columns (= `mac_o` lanes)
- `MAC_W`, 19, MAC result width, signed two's complement
- `FIFO_DEPTH`, 8, entries per column FIFO, power of two ≥ 2
- `VEC_NUM`, 8, result vectors per frame (= rbuf depth)

Ports:
- `clk_i`  in  1  sole clock, all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_vi`  in  1  frame start pulse, same signal that starts `pe_array`
- `mac_i`  in  ARRAY_WIDTH×MAC_W  per-column results from `pe_array.mac_o`
- `mac_v_i`  in  ARRAY_WIDTH  per-column valid from `pe_array.mac_v_o`
- `res_o`  out  ARRAY_WIDTH×MAC_W  aligned result vector
- `res_v_o`  out  1  `res_o` valid
- `res_ready_i`  in  1  consumer accepts `res_o`
- `res_last_o`  out  1  high with the frame's final vector (index VEC_NUM-1)
- `ovf_o`  out  1  sticky overflow, a sample was dropped

## Operation
- Column c: `mac_v_i[c]` high pushes `mac_i[c]` into FIFO c. Columns are independent and arrive skewed, column c one cycle after column c-1.
- `res_v_o` = all ARRAY_WIDTH FIFOs non-empty. `res_o[c]` is the head of FIFO c, driven combinationally from the FIFO read port.
- Handshake: pop all FIFOs together when `res_v_o && res_ready_i`. Once `res_v_o` is high, it and `res_o` stay stable until accepted.
- Vector counter `vec_cnt`, 0..VEC_NUM-1, increments on each accepted vector and wraps to 0 after VEC_NUM-1. `res_last_o` = `res_v_o && vec_cnt==VEC_NUM-1`.
- Full FIFO c with push and no same-cycle pop: the sample is dropped, FIFO c is unchanged and `ovf_o` sets.
- Full FIFO c with push and same-cycle pop: the push is accepted.
- Empty FIFO: a pop cannot occur, because `res_v_o` is low.
- `start_vi`: synchronously empties all FIFOs and clears `vec_cnt` and `ovf_o`. Any `mac_v_i` in the same cycle is ignored.
- `rst_i`: same clearing effect as `start_vi`. It may arrive mid-frame; partial data is discarded.

## Timing
- Reset values: `res_v_o`=0, `res_last_o`=0, `ovf_o`=0, `res_o`=0 (FIFO storage cleared), `vec_cnt`=0.
- Latency: a push at edge N is visible at the FIFO head after edge N. `res_v_o` rises the cycle after the last column (ARRAY_WIDTH-1) pushes vector k.
- Throughput: one vector per cycle with `res_ready_i` held high.
- `ovf_o` sets the cycle after the dropping edge and holds until `start_vi` or `rst_i`.
- Steady state: column 0 runs ARRAY_WIDTH-1 entries ahead of the last column, so FIFO_DEPTH ≥ ARRAY_WIDTH is required for stall-free operation. A per-FIFO occupancy counter is width $clog2(FIFO_DEPTH)+1.

## Configuration
- `PE_COLLECT_RELU_EN` defined: each lane of `res_o` is replaced by 0 when its MSB is 1 (negative). This is applied at the output mux after the FIFO read; stored data is unchanged.
- Not defined: `res_o` passes raw signed MAC values.
- Handshake and counters are identical in both builds.

## Structure
- `pe_pkg`: `ARRAY_WIDTH`, `MAC_W`, `VEC_NUM` constants shared with `pe_array`, plus `typedef logic [MAC_W-1:0] mac_t` and `typedef mac_t [ARRAY_WIDTH-1:0] mac_vec_t`.
- Sub-module `pe_col_fifo`: synchronous single-clock FIFO with push, pop, full, empty, head data and clear, one instance per column. The top level holds the all-non-empty AND, `vec_cnt`, the overflow flag and the ReLU stage.

## Test plan
- Reset, then idle: `res_v_o`=0, `res_last_o`=0, `ovf_o`=0, `res_o`=0.
- Skewed frame: column c pushes value 100·k+c at cycle k+c for k=0..7, `res_ready_i`=1. Expect 8 vectors with `res_o[c]`=100·k+c in order, and `res_last_o` only on k=7.
- Backpressure: same frame with `res_ready_i` low for 4 cycles mid-stream. `res_o` holds stable, no `ovf_o`, all 8 vectors delivered.
- Overflow: FIFO_DEPTH=8, `res_ready_i`=0, 9 pushes to column 0. `ovf_o`=1, the 9th value is dropped, the first 8 are delivered; `start_vi` clears `ovf_o`.
- Full plus simultaneous pop: column FIFOs full, `res_ready_i`=1 with a push on all columns. Push accepted, no `ovf_o`.
- `PE_COLLECT_RELU_EN`: push −5 (19'h7FFFB) and +7. Output is 0 and 7; without the macro, 19'h7FFFB and 7.
